if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/if_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  localparam logic [XLEN-1:0] PC_RESET  = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_payload_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble clears the instruction and valid but keeps the PC.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_bubble,
  input  ifid_payload_t   i_payload,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= PC_RESET;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_payload.instr;
      r_pc    <= i_payload.pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM (FETCH/HOLD/DROP) and the IF/ID register.
// Define IF_FLUSH_EN to make a redirect squash the IF/ID register even under stall.
module if_stage
  import if_stage_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            stall,
  input  logic            PCSource,
  input  logic [XLEN-1:0] jumpTarget,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic [XLEN-1:0] imemData,
  input  logic            imemAck,
  output logic [XLEN-1:0] instructions,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic            IF_ID_valid
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_hold_instr;
  logic [XLEN-1:0] r_hold_pc;
  logic [XLEN-1:0] r_drop_addr;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;

  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_jump_pc;
  logic            w_load_fetch;
  logic            w_load_hold;
  logic            w_load;
  logic            w_bubble;
  logic            w_flush;
  ifid_payload_t   w_payload;

  assign w_pc_plus = r_pc + PC_STEP;
  assign w_jump_pc = jumpTarget & ALIGN_MASK;

`ifdef IF_FLUSH_EN
  assign w_flush = PCSource;
`else
  assign w_flush = 1'b0;
`endif

  // IF/ID control: load from memory or hold buffer, otherwise bubble unless stalled.
  assign w_load_fetch = (r_state == FETCH) && imemAck && !stall && !PCSource;
  assign w_load_hold  = (r_state == HOLD) && !stall && !PCSource;
  assign w_load       = w_load_fetch || w_load_hold;
  assign w_bubble     = w_flush || (!stall && !w_load);
  assign w_payload.instr = w_load_fetch ? imemData : r_hold_instr;
  assign w_payload.pc    = w_load_fetch ? w_pc_plus : r_hold_pc;

  // Fetch FSM; imemReq/imemAddr are registered with the value of the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= FETCH;
      r_pc         <= PC_RESET;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= PC_RESET;
      r_drop_addr  <= PC_RESET;
      r_imem_req   <= 1'b1;
      r_imem_addr  <= PC_RESET;
    end else if (PCSource) begin
      r_pc <= w_jump_pc;
      case (r_state)
        FETCH: begin
          if (imemAck) begin
            r_imem_addr <= w_jump_pc;
          end else begin
            r_drop_addr <= r_pc;
            r_state     <= DROP;
          end
        end
        HOLD: begin
          r_state     <= FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= w_jump_pc;
        end
        DROP: begin
          if (imemAck) begin
            r_state     <= FETCH;
            r_imem_addr <= w_jump_pc;
          end
        end
        default: begin
          r_state     <= FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= w_jump_pc;
        end
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (imemAck) begin
            r_pc        <= w_pc_plus;
            r_imem_addr <= w_pc_plus;
            if (stall) begin
              r_hold_instr <= imemData;
              r_hold_pc    <= w_pc_plus;
              r_state      <= HOLD;
              r_imem_req   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            r_state     <= FETCH;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end
        DROP: begin
          if (imemAck) begin
            r_state     <= FETCH;
            r_imem_addr <= r_pc;
          end
        end
        default: begin
          r_state     <= FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
        end
      endcase
    end
  end

  assign imemReq  = r_imem_req;
  assign imemAddr = r_imem_addr;

  if_id_reg u_if_id_reg (
    .clk       (Clk),
    .rst       (Reset),
    .i_load    (w_load),
    .i_bubble  (w_bubble),
    .i_payload (w_payload),
    .o_instr   (instructions),
    .o_pc      (IF_ID_PC),
    .o_valid   (IF_ID_valid)
  );

endmodule
